// File: rtl/pwm_decoder_if.sv
// Purpose : PWM decoder line-in / recovered-sample-out bundle (master = line driver + consumer, slave = decoder).
// Latency : none, wiring only.
// Backpr. : none; the decoder samples pwm_i every cycle and results are single-cycle pulses.
interface pwm_decoder_if #(
    parameter int PERIOD_W = 8
);
    logic                en;
    logic                pwm_i;
    logic [PERIOD_W-1:0] sample_o;
    logic                valid_o;
    logic                locked_o;
    logic                error_o;

    modport master (
        output en,
        output pwm_i,
        input  sample_o,
        input  valid_o,
        input  locked_o,
        input  error_o
    );

    modport slave (
        input  en,
        input  pwm_i,
        output sample_o,
        output valid_o,
        output locked_o,
        output error_o
    );
endinterface

// File: rtl/pwm_decoder.sv
// Purpose : recover the PWM sample by aligning to the 2^PERIOD_W frame and counting high cycles;
//           optional 3-tap majority glitch filter when PWM_DEC_GLITCH_FILTER_EN is defined.
// Latency : first valid_o SYNC_STAGES+2^PERIOD_W+1 cycles after pwm_i first seen high (+1 with filter).
// Backpr. : none; the line is sampled every cycle, valid_o/error_o are unconditional one-cycle pulses.
module pwm_decoder #(
    parameter int PERIOD_W    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          n_rst,
    pwm_decoder_if.slave  bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [PERIOD_W-1:0] WCNT_LAST = '1;

    // ------------------------------------------------------------------
    // Input path: synchronizer, optional majority filter, edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   pwm_sync;
    logic                   pwm_s;
    logic                   pwm_s_q, pwm_s_d;
    logic                   rise;

    // Shift the raw line into the synchronizer chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.pwm_i};
    end

    assign pwm_sync = sync_q[SYNC_STAGES-1];

`ifdef PWM_DEC_GLITCH_FILTER_EN
    logic [1:0] hist_q, hist_d;

    // Keep the two previous synchronized samples for the majority vote.
    always_comb begin
        hist_d = {hist_q[0], pwm_sync};
    end

    // History register for the majority filter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // Two of three agreeing samples win, so a lone one-cycle pulse never reaches the counter.
    assign pwm_s = (pwm_sync & hist_q[0]) | (pwm_sync & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
    assign pwm_s = pwm_sync;
`endif

    assign pwm_s_d = pwm_s;
    assign rise    = pwm_s & ~pwm_s_q;

    // Synchronizer and edge-detect history; keeps running while disabled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q  <= '0;
            pwm_s_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            pwm_s_q <= pwm_s_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame alignment FSM
    // ------------------------------------------------------------------
    state_t state_q, state_d;

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: lock on the first rising edge; disable always drops back to IDLE.
    always_comb begin
        state_d = state_q;
        if (!bus.en) begin
            state_d = IDLE;
        end else if (state_q == IDLE && rise) begin
            state_d = LOCKED;
        end
    end

    // ------------------------------------------------------------------
    // Window / high counters and registered outputs
    // ------------------------------------------------------------------
    // wcnt_q is the offset of the current cycle; hcnt_q counts high cycles in earlier offsets.
    logic [PERIOD_W-1:0] wcnt_q, wcnt_d;
    logic [PERIOD_W:0]   hcnt_q, hcnt_d;
    logic [PERIOD_W:0]   total;
    logic [PERIOD_W-1:0] sample_q, sample_d;
    logic                valid_q, valid_d;
    logic                error_q, error_d;

    assign total = hcnt_q + {{PERIOD_W{1'b0}}, pwm_s};

    // Output/datapath logic: count, close windows, and realign on unexpected edges.
    always_comb begin
        wcnt_d   = wcnt_q;
        hcnt_d   = hcnt_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        error_d  = 1'b0;
        if (!bus.en) begin
            wcnt_d = '0;
            hcnt_d = '0;
        end else if (state_q == IDLE) begin
            if (rise) begin
                // This cycle is offset 0 and it is already high.
                wcnt_d = PERIOD_W'(1);
                hcnt_d = (PERIOD_W+1)'(1);
            end
        end else if (rise && wcnt_q != '0) begin
            // Edge in the wrong place: drop the partial window and restart here.
            error_d = 1'b1;
            wcnt_d  = PERIOD_W'(1);
            hcnt_d  = (PERIOD_W+1)'(1);
        end else if (wcnt_q == WCNT_LAST) begin
            valid_d = 1'b1;
            wcnt_d  = '0;
            hcnt_d  = '0;
            if (total[PERIOD_W]) begin
                // High for the full frame is not a legal PWM code: saturate and flag it.
                sample_d = '1;
                error_d  = 1'b1;
            end else begin
                sample_d = total[PERIOD_W-1:0];
            end
        end else begin
            wcnt_d = wcnt_q + PERIOD_W'(1);
            hcnt_d = total;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wcnt_q   <= '0;
            hcnt_q   <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            wcnt_q   <= wcnt_d;
            hcnt_q   <= hcnt_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            error_q  <= error_d;
        end
    end

    assign bus.sample_o = sample_q;
    assign bus.valid_o  = valid_q;
    assign bus.error_o  = error_q;
    assign bus.locked_o = (state_q == LOCKED);

endmodule

// File: tb/tb_pwm_decoder.sv
// Purpose : directed, table-driven check of pwm_decoder against hand-computed frame results.
// Latency : one step = one clock; inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpr. : none.
module tb_pwm_decoder;
    localparam int PW    = 8;
    localparam int FRAME = 256;
    // Step distance from a frame's first driven step to the negedge where its valid_o is seen:
    // 2 sync flops + 256 window cycles, observed in the cycle after the closing edge.
`ifdef PWM_DEC_GLITCH_FILTER_EN
    localparam int LAT = 259;
`else
    localparam int LAT = 258;
`endif

    typedef struct {
        int val;
        int exp_samp;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst;

    pwm_decoder_if #(.PERIOD_W(PW)) bus ();

    pwm_decoder #(.PERIOD_W(PW), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int step     = 0;
    int v_step[$];
    int v_samp[$];
    int v_err[$];
    int e_step[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic step_cyc(input logic p);
        bus.pwm_i = p;
        @(negedge clk);
        if (bus.valid_o === 1'b1) begin
            v_step.push_back(step);
            v_samp.push_back(int'(bus.sample_o));
            v_err.push_back(int'(bus.error_o));
        end
        if (bus.error_o === 1'b1) e_step.push_back(step);
        step++;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int v);
        for (int i = 0; i < FRAME; i++) step_cyc(i < v);
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step_cyc(1'b0);
    endtask

    task automatic clear_log();
        v_step.delete();
        v_samp.delete();
        v_err.delete();
        e_step.delete();
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        idle_steps(2);
        n_rst = 1'b1;
        idle_steps(4);
        clear_log();
    endtask

    task automatic check_valid(input string name, input int idx, input int exp_step,
                               input int exp_samp, input int exp_err);
        if (idx < v_step.size()) begin
            check({name, "_step"}, v_step[idx], exp_step);
            check({name, "_sample"}, v_samp[idx], exp_samp);
            check({name, "_err"}, v_err[idx], exp_err);
        end else begin
            check({name, "_present"}, v_step.size(), idx + 1);
        end
    endtask

    initial begin
        int base;
        int base2;

        vecs[0] = '{8'h80, 8'h80};
        vecs[1] = '{8'h80, 8'h80};
        vecs[2] = '{8'h80, 8'h80};
`ifdef PWM_DEC_GLITCH_FILTER_EN
        vecs[3] = '{8'h01, 8'h00};
`else
        vecs[3] = '{8'h01, 8'h01};
`endif
        vecs[4] = '{8'h7F, 8'h7F};
        vecs[5] = '{8'hFF, 8'hFF};
        vecs[6] = '{8'h00, 8'h00};
        vecs[7] = '{8'h80, 8'h80};

        // Reset held with the line toggling.
        bus.en    = 1'b1;
        bus.pwm_i = 1'b0;
        n_rst     = 1'b0;
        for (int i = 0; i < 8; i++) step_cyc(i[0]);
        check("rst_sample", bus.sample_o, 0);
        check("rst_valid", bus.valid_o, 0);
        check("rst_locked", bus.locked_o, 0);
        check("rst_error", bus.error_o, 0);

        // Release reset with the line low: must stay idle.
        n_rst = 1'b1;
        clear_log();
        idle_steps(20);
        check("idle_locked", bus.locked_o, 0);
        check("idle_no_valid", v_step.size(), 0);

        // Table of back-to-back frames.
        base = step;
        for (int k = 0; k < 8; k++) drive_frame(vecs[k].val);
        idle_steps(6);
        check("first_valid_cycle", (v_step.size() > 0) ? v_step[0] - base + 1 : 0, LAT + 1);
        for (int k = 0; k < 8; k++)
            check_valid($sformatf("vec%0d", k), k, base + LAT + k * FRAME, vecs[k].exp_samp, 0);
        check("table_valid_count", v_step.size(), 8);
        check("table_error_count", e_step.size(), 0);
        check("table_locked", bus.locked_o, 1);

        // Misalignment: third frame arrives 5 cycles late.
        do_reset();
        base = step;
        drive_frame(128);
        drive_frame(128);
        idle_steps(5);
        drive_frame(128);
        drive_frame(128);
        idle_steps(6);
        check("mis_valid_count", v_step.size(), 4);
        check("mis_error_count", e_step.size(), 1);
        check("mis_error_step", (e_step.size() > 0) ? e_step[0] : -1, base + 2 * FRAME + 5 + LAT - 255);
        check_valid("mis0", 0, base + LAT, 128, 0);
        check_valid("mis1", 1, base + FRAME + LAT, 128, 0);
        check_valid("mis2", 2, base + 2 * FRAME + 5 + LAT, 128, 0);
        check_valid("mis3", 3, base + 3 * FRAME + 5 + LAT, 128, 0);
        check("mis_locked", bus.locked_o, 1);

        // Stuck high after lock.
        do_reset();
        base = step;
        drive_frame(128);
        for (int i = 0; i < 2 * FRAME + 4; i++) step_cyc(1'b1);
        check("stuck_valid_count", v_step.size(), 3);
        check("stuck_error_count", e_step.size(), 2);
        check_valid("stuck0", 0, base + LAT, 128, 0);
        check_valid("stuck1", 1, base + FRAME + LAT, 255, 1);
        check_valid("stuck2", 2, base + 2 * FRAME + LAT, 255, 1);

        // One-cycle glitch at offset 100 of a 0x40 frame.
        do_reset();
        base = step;
        drive_frame(64);
        for (int i = 0; i < FRAME; i++) step_cyc((i < 64) || (i == 100));
        drive_frame(64);
        idle_steps(6);
`ifdef PWM_DEC_GLITCH_FILTER_EN
        check("glitch_error_count", e_step.size(), 0);
        check("glitch_valid_count", v_step.size(), 3);
        check_valid("glitch0", 0, base + LAT, 64, 0);
        check_valid("glitch1", 1, base + FRAME + LAT, 64, 0);
        check_valid("glitch2", 2, base + 2 * FRAME + LAT, 64, 0);
`else
        check("glitch_error_count", e_step.size(), 2);
        check("glitch_error_step", (e_step.size() > 0) ? e_step[0] : -1, base + FRAME + 100 + LAT - 255);
        check("glitch_valid_count", v_step.size(), 2);
        check_valid("glitch0", 0, base + LAT, 64, 0);
        check_valid("glitch1", 1, base + 2 * FRAME + LAT, 64, 0);
`endif

        // Enable dropped mid-window, then re-enabled.
        do_reset();
        base = step;
        drive_frame(128);
        for (int i = 0; i < 50; i++) step_cyc(1'b1);
        check("en_locked_before", bus.locked_o, 1);
        bus.en = 1'b0;
        step_cyc(1'b1);
        check("en_locked_after", bus.locked_o, 0);
        check("en_sample_held", bus.sample_o, 128);
        for (int i = 51; i < FRAME; i++) step_cyc(i < 128);
        drive_frame(32);
        check("en_off_valid_count", v_step.size(), 1);
        check("en_off_error_count", e_step.size(), 0);
        check("en_off_sample", bus.sample_o, 128);
        check("en_off_locked", bus.locked_o, 0);
        bus.en = 1'b1;
        base2 = step;
        drive_frame(16);
        drive_frame(16);
        idle_steps(6);
        check("en_relock_valid_count", v_step.size(), 3);
        check_valid("en_relock0", 1, base2 + LAT, 16, 0);
        check_valid("en_relock1", 2, base2 + FRAME + LAT, 16, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
